// File: rtl/kart_physics_core.sv
// kart_physics_core
// Per-kart motion integrator. On each physics tick it turns the heading toward
// the requested direction along the shortest path, accelerates or bleeds speed
// toward the active cap, and advances a fixed-point position along the
// quantised heading. The position is clamped to the map, and a clamp costs
// half the speed.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-low reset
//   tick      physics update strobe, one-cycle pulse
//   state     game state (IDLE=0 SETTING=1 COUNTDOWN=3 RACING=4 PAUSE=5 FINISH=6)
//   h_code    0 nil, 1 left, 2 right, 3 nil
//   v_code    0 nil, 1 up, 2 down, 3 nil
//   boost     boost request
//   pos_x     integer x position (px)
//   pos_y     integer y position (px)
//   angle     heading in degrees 0..359; 0 = up (-y), 90 = right (+x)
//   speed     current speed in 2^-SPEED_FRAC px/tick
//   moving    speed != 0
//   wall_hit  one-cycle pulse after a tick that clamped either axis
//
// Strobe semantics: tick carries no handshake. A cycle with tick high is one
// update request and is always consumed. Its result is visible on the
// registered outputs in the following cycle. A cycle with tick low changes
// nothing except that wall_hit drops.
module kart_physics_core #(
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int MAP_MAX_X   = 320,
    parameter int MAP_MAX_Y   = 240,
    parameter int POS_W       = 10,
    parameter int SPD_W       = 10,
    parameter int SPEED_FRAC  = 4,
    parameter int MAX_SPEED   = 30,
    parameter int BOOST_MAX   = 48,
    parameter int ACCEL       = 1,
    parameter int BOOST_ACCEL = 5,
    parameter int DECEL       = 1,
    parameter int TURN_STEP   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [2:0]       state,
    input  logic [1:0]       h_code,
    input  logic [1:0]       v_code,
    input  logic             boost,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [8:0]       angle,
    output logic [SPD_W-1:0] speed,
    output logic             moving,
    output logic             wall_hit
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTING   = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd3;
    localparam logic [2:0] ST_RACING    = 3'd4;
    localparam logic [2:0] ST_PAUSE     = 3'd5;

    // The accumulator holds the speed fraction plus the Q0.8 unit-vector
    // fraction, so speed * unit adds exactly, with no rounding.
    localparam int FRAC  = 8 + SPEED_FRAC;
    localparam int INT_W = POS_W + 2;
    localparam int ACC_W = INT_W + FRAC;

    localparam logic signed [ACC_W-1:0] START_ACC_X = {INT_W'(START_X), {FRAC{1'b0}}};
    localparam logic signed [ACC_W-1:0] START_ACC_Y = {INT_W'(START_Y), {FRAC{1'b0}}};
    localparam logic signed [INT_W-1:0] X_HI_INT    = INT_W'(MAP_MAX_X - 1);
    localparam logic signed [INT_W-1:0] Y_HI_INT    = INT_W'(MAP_MAX_Y - 1);
    localparam logic signed [ACC_W-1:0] X_HI_ACC    = {X_HI_INT, {FRAC{1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_HI_ACC    = {Y_HI_INT, {FRAC{1'b0}}};

    localparam logic [SPD_W-1:0] DECEL_W = SPD_W'(DECEL);
    localparam logic [9:0]       TSTEP   = 10'(TURN_STEP);
    localparam logic signed [9:0] U_AX   = 10'sd256;
    localparam logic signed [9:0] U_DG   = 10'sd181;

    logic signed [ACC_W-1:0] acc_x, acc_y;

    logic              h_l, h_r, v_u, v_d, dir_valid;
    logic [8:0]        target;
    logic [9:0]        diff_raw, diff, turn_amt, a10;
    logic [8:0]        ang_race;
    logic [SPD_W-1:0]  cap, gain, spd_upd, spd_race;
    logic [SPD_W:0]    spd_sum;
    logic signed [9:0] unit_x, unit_y;
    logic signed [SPD_W:0]   spd_s;
    logic signed [ACC_W-1:0] prod_x, prod_y, sum_x, sum_y, new_x, new_y;
    logic signed [INT_W-1:0] int_x, int_y;
    logic              x_lo, x_hi, y_lo, y_hi, hit;

    logic signed [ACC_W-1:0] acc_x_nxt, acc_y_nxt;
    logic [8:0]        ang_nxt;
    logic [SPD_W-1:0]  spd_nxt;
    logic              wall_nxt;

    // Heading target, turning and speed update.
    always_comb begin
        h_l       = (h_code == 2'd1);
        h_r       = (h_code == 2'd2);
        v_u       = (v_code == 2'd1);
        v_d       = (v_code == 2'd2);
        dir_valid = h_l | h_r | v_u | v_d;

        if (v_u)      target = h_l ? 9'd315 : (h_r ? 9'd45  : 9'd0);
        else if (v_d) target = h_l ? 9'd225 : (h_r ? 9'd135 : 9'd180);
        else          target = h_l ? 9'd270 : 9'd90;

        // (target - angle) mod 360, kept non-negative.
        diff_raw = {1'b0, target} + 10'd360 - {1'b0, angle};
        diff     = (diff_raw >= 10'd360) ? diff_raw - 10'd360 : diff_raw;

        turn_amt = 10'd0;
        a10      = {1'b0, angle};
        if (dir_valid && diff != 10'd0) begin
            if (diff <= 10'd180) begin
                // A diff of exactly 180 lands here, so it turns clockwise.
                turn_amt = (diff < TSTEP) ? diff : TSTEP;
                a10      = {1'b0, angle} + turn_amt;
            end else begin
                turn_amt = ((10'd360 - diff) < TSTEP) ? (10'd360 - diff) : TSTEP;
                a10      = {1'b0, angle} + 10'd360 - turn_amt;
            end
            if (a10 >= 10'd360) a10 = a10 - 10'd360;
        end
        ang_race = a10[8:0];

        cap     = boost ? SPD_W'(BOOST_MAX) : SPD_W'(MAX_SPEED);
        gain    = boost ? SPD_W'(BOOST_ACCEL) : SPD_W'(ACCEL);
        spd_sum = {1'b0, speed} + {1'b0, gain};
        if (!dir_valid)
            spd_upd = (speed > DECEL_W) ? speed - DECEL_W : '0;
        else if (speed < cap)
            spd_upd = (spd_sum > {1'b0, cap}) ? cap : spd_sum[SPD_W-1:0];
        else if (speed > cap)
            // The boost cap was released: bleed down to the normal cap, not below it.
            spd_upd = ((speed - cap) > DECEL_W) ? speed - DECEL_W : cap;
        else
            spd_upd = speed;
    end

    // Movement along the current heading sector, followed by the edge clamp.
    always_comb begin
        // sector = ((angle + 22) / 45) mod 8, written as threshold compares.
        unit_x = 10'sd0;
        unit_y = 10'sd0;
        if      (angle < 9'd23)  begin unit_x = 10'sd0; unit_y = -U_AX; end
        else if (angle < 9'd68)  begin unit_x = U_DG;   unit_y = -U_DG; end
        else if (angle < 9'd113) begin unit_x = U_AX;   unit_y = 10'sd0; end
        else if (angle < 9'd158) begin unit_x = U_DG;   unit_y = U_DG;  end
        else if (angle < 9'd203) begin unit_x = 10'sd0; unit_y = U_AX;  end
        else if (angle < 9'd248) begin unit_x = -U_DG;  unit_y = U_DG;  end
        else if (angle < 9'd293) begin unit_x = -U_AX;  unit_y = 10'sd0; end
        else if (angle < 9'd338) begin unit_x = -U_DG;  unit_y = -U_DG; end
        else                     begin unit_x = 10'sd0; unit_y = -U_AX; end

        // Movement uses the speed and heading held before this tick.
        spd_s  = {1'b0, speed};
        prod_x = ACC_W'(spd_s) * ACC_W'(unit_x);
        prod_y = ACC_W'(spd_s) * ACC_W'(unit_y);
        sum_x  = acc_x + prod_x;
        sum_y  = acc_y + prod_y;
        int_x  = sum_x[ACC_W-1:FRAC];
        int_y  = sum_y[ACC_W-1:FRAC];

        x_lo = sum_x[ACC_W-1];
        x_hi = !x_lo && (int_x > X_HI_INT);
        y_lo = sum_y[ACC_W-1];
        y_hi = !y_lo && (int_y > Y_HI_INT);

        new_x = x_lo ? '0 : (x_hi ? X_HI_ACC : sum_x);
        new_y = y_lo ? '0 : (y_hi ? Y_HI_ACC : sum_y);
        // A clamp on both axes in the same tick still counts as one hit.
        hit      = x_lo | x_hi | y_lo | y_hi;
        spd_race = hit ? (spd_upd >> 1) : spd_upd;
    end

    // Per-state next values applied on a tick.
    always_comb begin
        acc_x_nxt = acc_x;
        acc_y_nxt = acc_y;
        ang_nxt   = angle;
        spd_nxt   = speed;
        wall_nxt  = 1'b0;
        case (state)
            ST_RACING: begin
                acc_x_nxt = new_x;
                acc_y_nxt = new_y;
                ang_nxt   = ang_race;
                spd_nxt   = spd_race;
                wall_nxt  = hit;
            end
            ST_PAUSE: ;
            ST_IDLE, ST_SETTING, ST_COUNTDOWN: begin
                acc_x_nxt = START_ACC_X;
                acc_y_nxt = START_ACC_Y;
                ang_nxt   = 9'd0;
                spd_nxt   = '0;
            end
            default: spd_nxt = '0;  // FINISH and the undefined codes
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_x    <= START_ACC_X;
            acc_y    <= START_ACC_Y;
            angle    <= 9'd0;
            speed    <= '0;
            moving   <= 1'b0;
            wall_hit <= 1'b0;
        end else begin
            wall_hit <= 1'b0;
            if (tick) begin
                acc_x    <= acc_x_nxt;
                acc_y    <= acc_y_nxt;
                angle    <= ang_nxt;
                speed    <= spd_nxt;
                moving   <= (spd_nxt != '0);
                wall_hit <= wall_nxt;
            end
        end
    end

    assign pos_x = acc_x[FRAC +: POS_W];
    assign pos_y = acc_y[FRAC +: POS_W];

endmodule

// File: tb/tb_kart_physics_core.sv
// Bench for kart_physics_core, built with START = (5,100) and all other
// parameters at their defaults.
module tb_kart_physics_core;

    localparam int SX  = 5;
    localparam int SY  = 100;
    localparam int MX  = 320;
    localparam int MY  = 240;
    localparam int ONE = 4096;  // 1 px in accumulator units (2^(8+4))

    localparam logic [2:0] S_COUNT = 3'd3, S_RACE = 3'd4, S_PAUSE = 3'd5, S_FIN = 3'd6;
    localparam logic [40:0] RESET_VEC = {10'(SX), 10'(SY), 9'd0, 10'd0, 1'b0, 1'b0};

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] state = 3'd0;
    logic [1:0] h_code = 2'd0;
    logic [1:0] v_code = 2'd0;
    logic       boost = 1'b0;
    logic [9:0] pos_x, pos_y, speed;
    logic [8:0] angle;
    logic       moving, wall_hit;

    always #5 clk = ~clk;

    kart_physics_core #(.START_X(SX), .START_Y(SY)) dut (
        .clk(clk), .rst(rst), .tick(tick), .state(state),
        .h_code(h_code), .v_code(v_code), .boost(boost),
        .pos_x(pos_x), .pos_y(pos_y), .angle(angle), .speed(speed),
        .moving(moving), .wall_hit(wall_hit)
    );

    // ---------------- reference model ----------------
    int m_ax, m_ay, m_ang, m_spd;
    bit m_wall;

    task automatic model_reset();
        m_ax = SX * ONE; m_ay = SY * ONE; m_ang = 0; m_spd = 0; m_wall = 0;
    endtask

    function automatic logic [40:0] model_vec();
        return {10'(m_ax / ONE), 10'(m_ay / ONE), 9'(m_ang), 10'(m_spd),
                1'(m_spd != 0), 1'(m_wall)};
    endfunction

    task automatic model_step(input logic [2:0] st, input logic [1:0] h,
                              input logic [1:0] v, input logic b);
        int tgt_tab[3][3] = '{'{315, 0, 45}, '{270, -1, 90}, '{225, 180, 135}};
        int ux[8] = '{0, 181, 256, 181, 0, -181, -256, -181};
        int uy[8] = '{-256, -181, 0, 181, 256, 181, 0, -181};
        int dx, dy, tgt, diff, sec, cap, gain, amt;
        bit hit;
        m_wall = 0;
        case (st)
            3'd4: begin
                dx  = (h == 2'd1) ? -1 : ((h == 2'd2) ? 1 : 0);
                dy  = (v == 2'd1) ? -1 : ((v == 2'd2) ? 1 : 0);
                sec = ((m_ang + 22) / 45) % 8;
                m_ax += m_spd * ux[sec];
                m_ay += m_spd * uy[sec];
                if (dx != 0 || dy != 0) begin
                    tgt  = tgt_tab[dy + 1][dx + 1];
                    diff = (tgt - m_ang + 360) % 360;
                    if (diff != 0 && diff <= 180) begin
                        amt   = (diff < 3) ? diff : 3;
                        m_ang = (m_ang + amt) % 360;
                    end else if (diff > 180) begin
                        amt   = ((360 - diff) < 3) ? (360 - diff) : 3;
                        m_ang = (m_ang - amt + 360) % 360;
                    end
                    cap  = b ? 48 : 30;
                    gain = b ? 5 : 1;
                    if (m_spd < cap)      m_spd = (m_spd + gain > cap) ? cap : m_spd + gain;
                    else if (m_spd > cap) m_spd = (m_spd - 1 < cap) ? cap : m_spd - 1;
                end else begin
                    m_spd = (m_spd > 1) ? m_spd - 1 : 0;
                end
                hit = 0;
                if (m_ax < 0) begin m_ax = 0; hit = 1; end
                else if (m_ax >= MX * ONE) begin m_ax = (MX - 1) * ONE; hit = 1; end
                if (m_ay < 0) begin m_ay = 0; hit = 1; end
                else if (m_ay >= MY * ONE) begin m_ay = (MY - 1) * ONE; hit = 1; end
                if (hit) m_spd = m_spd / 2;
                m_wall = hit;
            end
            3'd5: ;
            3'd0, 3'd1, 3'd3: begin
                m_ax = SX * ONE; m_ay = SY * ONE; m_ang = 0; m_spd = 0;
            end
            default: m_spd = 0;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    logic [40:0] exp_q[$];
    logic [40:0] hold_exp = RESET_VEC;
    logic        tick_seen = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check_vec(input string name, input logic [40:0] e);
        logic [40:0] g;
        g = {pos_x, pos_y, angle, speed, moving, wall_hit};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s @%0t: got x=%0d y=%0d ang=%0d spd=%0d mov=%0b wall=%0b expected x=%0d y=%0d ang=%0d spd=%0d mov=%0b wall=%0b",
                     name, $time, g[40:31], g[30:21], g[20:12], g[11:2], g[1], g[0],
                     e[40:31], e[30:21], e[20:12], e[11:2], e[1], e[0]);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) tick_seen <= 1'b0;
        else      tick_seen <= tick;
    end

    // Monitor: after a tick pop and compare; otherwise outputs must hold with wall_hit low.
    always @(negedge clk) begin
        logic [40:0] e;
        if (!rst) begin
            hold_exp = RESET_VEC;
        end else if (tick_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tick_result @%0t: output after tick with no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                check_vec("tick_result", e);
                hold_exp = {e[40:1], 1'b0};
            end
        end else begin
            check_vec("idle_hold", hold_exp);
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_tick(input logic [2:0] st, input logic [1:0] h,
                              input logic [1:0] v, input logic b);
        @(negedge clk);
        state = st; h_code = h; v_code = v; boost = b; tick = 1'b1;
        model_step(st, h, v, b);
        exp_q.push_back(model_vec());
        @(negedge clk);
        tick   = 1'b0;
        // Inputs are scrambled between ticks; the core must ignore them.
        state  = 3'($urandom_range(0, 7));
        h_code = 2'($urandom_range(0, 3));
        v_code = 2'($urandom_range(0, 3));
        boost  = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic tick_n(input int n, input logic [2:0] st, input logic [1:0] h,
                          input logic [1:0] v, input logic b);
        for (int i = 0; i < n; i++) drive_tick(st, h, v, b);
    endtask

    task automatic do_async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_vec("async_reset", RESET_VEC);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] st;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_vec("reset_state", RESET_VEC);
        rst = 1'b1;

        // Straight up to the normal cap, then cruise.
        tick_n(1, S_COUNT, 2'd0, 2'd0, 1'b0);
        tick_n(38, S_RACE, 2'd0, 2'd1, 1'b0);

        // Turn through the 0/359 wrap, then a 180-degree reversal (clockwise).
        tick_n(3, S_RACE, 2'd1, 2'd1, 1'b0);
        tick_n(40, S_RACE, 2'd2, 2'd0, 1'b0);
        tick_n(64, S_RACE, 2'd1, 2'd0, 1'b0);

        // Boost to 48, bleed to 30 on release, then coast to a stop.
        tick_n(1, S_COUNT, 2'd0, 2'd0, 1'b0);
        tick_n(15, S_RACE, 2'd0, 2'd1, 1'b1);
        tick_n(22, S_RACE, 2'd0, 2'd1, 1'b0);
        tick_n(40, S_RACE, 2'd0, 2'd0, 1'b0);

        // Left into the x=0 edge, then up to y=0 and diagonally into the corner.
        tick_n(1, S_COUNT, 2'd0, 2'd0, 1'b0);
        tick_n(40, S_RACE, 2'd1, 2'd0, 1'b1);
        tick_n(120, S_RACE, 2'd0, 2'd1, 1'b1);
        tick_n(20, S_RACE, 2'd1, 2'd1, 1'b1);

        // Pause freezes, racing resumes, countdown reloads.
        tick_n(1, S_COUNT, 2'd0, 2'd0, 1'b0);
        tick_n(20, S_RACE, 2'd0, 2'd1, 1'b0);
        for (int i = 0; i < 10; i++)
            drive_tick(S_PAUSE, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
        tick_n(5, S_RACE, 2'd0, 2'd1, 1'b0);
        tick_n(1, S_COUNT, 2'd0, 2'd0, 1'b0);

        // FINISH and the undefined codes stop the kart but keep pose.
        tick_n(12, S_RACE, 2'd2, 2'd2, 1'b0);
        tick_n(2, S_FIN, 2'd1, 2'd1, 1'b1);
        tick_n(4, S_RACE, 2'd2, 2'd0, 1'b0);
        tick_n(1, 3'd2, 2'd1, 2'd0, 1'b0);
        tick_n(4, S_RACE, 2'd2, 2'd0, 1'b0);
        tick_n(1, 3'd7, 2'd1, 2'd0, 1'b0);

        // Randomised mix, mostly racing.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      st = S_RACE;
            else if (r == 6) st = S_PAUSE;
            else if (r == 7) st = S_FIN;
            else if (r == 8) st = S_COUNT;
            else             st = 3'($urandom_range(0, 7));
            drive_tick(st, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between clock edges mid-race.
        tick_n(1, S_COUNT, 2'd0, 2'd0, 1'b0);
        tick_n(12, S_RACE, 2'd2, 2'd1, 1'b1);
        do_async_reset();
        tick_n(6, S_RACE, 2'd2, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expected results never produced, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kart_physics_core.md
Name: kart_physics_core

Overview:
- Parametrised successor to the single-kart physics block. Sits between the operation/state encoders and the renderer/collision logic.
- Adds heading-true motion: the kart moves along its quantised heading with fixed-point sub-pixel position instead of moving 1 px per key.
- Adds shortest-path turning with 0/359 wrap, a boost speed ceiling with bleed-off, and map-edge clamping with a speed penalty.
- All updates are gated by a physics tick strobe.

Parameters:
- START_X, 0, reset/reload x (px)
- START_Y, 0, reset/reload y (px)
- MAP_MAX_X, 320, x range 0..MAP_MAX_X-1
- MAP_MAX_Y, 240, y range 0..MAP_MAX_Y-1
- POS_W, 10, integer position width
- SPD_W, 10, speed width (unsigned)
- SPEED_FRAC, 4, speed unit = 2^-SPEED_FRAC px/tick
- MAX_SPEED, 30, normal cap
- BOOST_MAX, 48, cap while boost held
- ACCEL, 1, per-tick gain, normal
- BOOST_ACCEL, 5, per-tick gain, boost
- DECEL, 1, coast loss and over-cap bleed per tick
- TURN_STEP, 3, max degrees turned per tick

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  physics update strobe; one-cycle pulse
- state  in  3  game state: IDLE=0 SETTING=1 COUNTDOWN=3 RACING=4 PAUSE=5 FINISH=6
- h_code  in  2  0 nil, 1 left, 2 right, 3 treated as nil
- v_code  in  2  0 nil, 1 up, 2 down, 3 treated as nil
- boost  in  1  boost request
- pos_x  out  POS_W  integer x
- pos_y  out  POS_W  integer y
- angle  out  9  heading in degrees 0..359; 0 = up (−y), 90 = right (+x)
- speed  out  SPD_W  current speed
- moving  out  1  speed != 0
- wall_hit  out  1  one-cycle pulse on an edge clamp

Behaviour:
- Reset (rst low, async): pos = START (fraction 0), angle 0, speed 0, wall_hit 0. All outputs are registered.
- No register changes on cycles without tick, except that wall_hit clears. Tick-driven results appear the cycle after tick.
- State per tick:
  - RACING: full update as below.
  - PAUSE: everything holds.
  - IDLE/SETTING/COUNTDOWN: speed 0, angle 0, pos reloaded to START.
  - FINISH: speed 0, pos and angle hold.
  - Undefined codes behave as FINISH.
- Target angle comes combinationally from {h,v}: U 0, UR 45, R 90, DR 135, D 180, DL 225, L 270, UL 315. Nil input gives no target and no turning.
- Turning: diff = (target − angle) mod 360.
  - diff 0: hold.
  - diff ≤180: angle += min(TURN_STEP, diff).
  - Otherwise: angle −= min(TURN_STEP, 360−diff).
  - Results wrap modulo 360 and never overshoot the target.
  - diff exactly 180 turns clockwise.
- Speed:
  - Input non-nil: cap = boost ? BOOST_MAX : MAX_SPEED; gain = boost ? BOOST_ACCEL : ACCEL.
  - If speed < cap: speed = min(speed+gain, cap). If speed > cap (boost released): speed = max(speed−DECEL, cap).
  - Input nil: speed = max(speed−DECEL, 0). Never underflows.
- Heading sector = ((angle+22)/45) mod 8. Unit vector is Q0.8: axis ±256, diagonal ±181 per axis. The y component is negative for sectors 7, 0, 1.
- Position:
  - Accumulators are signed, POS_W+2 integer bits plus 8+SPEED_FRAC fraction bits.
  - Per tick: acc += speed×unit (exact, no rounding). Speed used is the pre-update value.
- Edge clamp, applied per axis after the add:
  - Integer part <0: set to 0, fraction cleared.
  - Integer part >MAP_MAX−1: set to MAP_MAX−1, fraction cleared.
  - Any clamp: speed (post-update) halved by right shift; wall_hit pulses.
  - Both axes clamping in the same tick: a single halving and a single pulse.
- Async reset mid-race returns every output to its reset value immediately.

Test Plan:
- Reset, RACING, v=up, MAX_SPEED reached (30 after 30 ticks) -> speed saturates at 30, angle stays 0; over the next 8 ticks pos_y decreases by exactly 15 px (30×256×8/4096), pos_x unchanged.
- angle 350, press right (target 90), TURN_STEP 3 -> 353, 356, 359, 2, ..., reaches 90 with no overshoot. Then from 90 press left (target 270, diff 180) -> angle increases toward 270.
- Hold boost until speed 48, release boost while holding up -> speed 47, 46, ... down to 30, then holds 30. Release all input -> decrements to 0 and stays 0, moving = 0.
- START (5,100), speed 40 heading 270 -> x clamps to 0 with fraction cleared, speed ≈20 after the halve, single wall_hit pulse. Heading 315 into the corner (0,0) -> one halve, one pulse.
- RACING at speed 20, switch to PAUSE for 10 ticks -> all outputs frozen. Back to RACING -> resumes from the same values. Switch to COUNTDOWN -> pos = START, speed 0, angle 0.
- Drop rst asynchronously between ticks mid-race -> outputs go to reset values before the next clk edge.
